mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto one
//               shared single-port memory. Only one access is in flight at a
//               time. Grants, completions and memory-side outputs are all
//               registered.
//               Optional macro ARB_ROUND_ROBIN_EN: when it is defined, a tie
//               between the two ports goes to the port that was not granted
//               last. When it is undefined, DM always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int ADDR_WIDTH_POW = 6
) (
  input  logic                              clk_in,
  input  logic                              reset,
  // instruction-fetch port
  input  logic                              if_req_in,
  input  logic [(1<<ADDR_WIDTH_POW)-1:0]    if_addr_in,
  output logic                              if_gnt_out,
  output logic                              if_valid_out,
  output logic [(1<<DATA_WIDTH_POW)-1:0]    if_rdata_out,
  // data port
  input  logic                              dm_req_in,
  input  logic                              dm_we_in,
  input  logic [(1<<ADDR_WIDTH_POW)-1:0]    dm_addr_in,
  input  logic [(1<<DATA_WIDTH_POW)-1:0]    dm_wdata_in,
  output logic                              dm_gnt_out,
  output logic                              dm_valid_out,
  output logic [(1<<DATA_WIDTH_POW)-1:0]    dm_rdata_out,
  // shared memory port
  output logic                              mem_en_out,
  output logic                              mem_we_out,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]    mem_addr_out,
  output logic [(1<<DATA_WIDTH_POW)-1:0]    mem_wdata_out,
  input  logic [(1<<DATA_WIDTH_POW)-1:0]    mem_rdata_in,
  input  logic                              mem_ready_in
);

  localparam int c_DATA_WIDTH = 1 << DATA_WIDTH_POW;
  localparam int c_ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_grant_if;
  logic   w_grant_dm;
  logic   w_done_if;
  logic   w_done_dm;
  logic   w_dm_wins;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when DM took the most recent grant. Reset value 0 makes DM preferred.
  logic r_last_dm;

  // A tie goes to the port that did not take the last grant.
  always_comb begin
    w_dm_wins = dm_req_in && (!if_req_in || !r_last_dm);
  end

  // Record which port took the latest grant.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_last_dm <= 1'b0;
    end else if (w_grant_dm) begin
      r_last_dm <= 1'b1;
    end else if (w_grant_if) begin
      r_last_dm <= 1'b0;
    end
  end
`else
  // Fixed priority: any DM request beats IF.
  always_comb begin
    w_dm_wins = dm_req_in;
  end
`endif

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and grant/completion strobes.
  always_comb begin
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_done_if    = 1'b0;
    w_done_dm    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // mem_ready_in is deliberately ignored here.
        if (w_dm_wins) begin
          w_grant_dm   = 1'b1;
          w_state_next = S_BUSY_DM;
        end else if (if_req_in) begin
          w_grant_if   = 1'b1;
          w_state_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF: begin
        if (mem_ready_in) begin
          w_done_if    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_BUSY_DM: begin
        if (mem_ready_in) begin
          w_done_dm    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs. The memory request is launched on a grant, held while
  // busy, and dropped on completion.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      if_gnt_out    <= 1'b0;
      dm_gnt_out    <= 1'b0;
      if_valid_out  <= 1'b0;
      dm_valid_out  <= 1'b0;
      if_rdata_out  <= '0;
      dm_rdata_out  <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      if_gnt_out   <= w_grant_if;
      dm_gnt_out   <= w_grant_dm;
      if_valid_out <= w_done_if;
      dm_valid_out <= w_done_dm;

      if (w_grant_if) begin
        // Fetches are always reads with zeroed write data.
        mem_en_out    <= 1'b1;
        mem_we_out    <= 1'b0;
        mem_addr_out  <= if_addr_in;
        mem_wdata_out <= {c_DATA_WIDTH{1'b0}};
      end else if (w_grant_dm) begin
        mem_en_out    <= 1'b1;
        mem_we_out    <= dm_we_in;
        mem_addr_out  <= dm_addr_in;
        mem_wdata_out <= dm_wdata_in;
      end else if (w_done_if || w_done_dm) begin
        mem_en_out    <= 1'b0;
        mem_we_out    <= 1'b0;
      end

      if (w_done_if) begin
        if_rdata_out <= mem_rdata_in;
      end
      if (w_done_dm) begin
        dm_rdata_out <= mem_rdata_in;
      end
    end
  end

endmodule
`default_nettype wire
